// File: rtl/wb_stage_if.sv
// Bundle of the write-back stage's upstream handshake, operand/result buses,
// load-return path and register-file write port, plus opcode category codes.

`ifndef WB_STAGE_OPCAT_DEFS
`define WB_STAGE_OPCAT_DEFS
`define INSTR_OPCAT_ADDSUB 4'd0
`define INSTR_OPCAT_LOGIC  4'd1
`define INSTR_OPCAT_SHIFT  4'd2
`define INSTR_OPCAT_MOVE   4'd3
`define INSTR_OPCAT_J      4'd4
`define INSTR_OPCAT_LD     4'd5
`define INSTR_OPCAT_ST     4'd6
`define INSTR_OPCAT_BR     4'd7
`define INSTR_OPCAT_SYS    4'd8
`endif

interface wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          valid;
    logic          ready;
    logic [5:0]    opcode;
    logic [AW-1:0] rd;
    logic [DW-1:0] pc;
    logic [DW-1:0] opgen;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic          mem_valid;
    logic [1:0]    ldsz;
    logic          ldsgn;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wrdata;
    logic          busy;
    logic          ld_err;

    modport master (
        output valid, opcode, rd, pc, opgen, alu, mem, mem_valid, ldsz, ldsgn,
        input  ready, wr_en, wr_addr, wrdata, busy, ld_err
    );

    modport slave (
        input  valid, opcode, rd, pc, opgen, alu, mem, mem_valid, ldsz, ldsgn,
        output ready, wr_en, wr_addr, wrdata, busy, ld_err
    );
endinterface

// File: rtl/wb_stage.sv
// Registered write-back stage: picks the result source by opcode category,
// extends sub-word loads, waits (with timeout) for late load data.

module wb_stage #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TMO    = 15,
    parameter int LD_EXT = 1
) (
    input logic      clk,
    input logic      rst,
    wb_stage_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0]    TMO_LAST = 8'(TMO - 1);
    localparam logic [DW-1:0] BYTE_HI  = ~(DW'(8'hFF));
    localparam logic [DW-1:0] HALF_HI  = ~(DW'(16'hFFFF));

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [AW-1:0] rd_q, rd_n;
    logic [1:0]    ldsz_q, ldsz_n;
    logic          ldsgn_q, ldsgn_n;
    logic          wr_en_q, wr_en_n;
    logic [AW-1:0] wr_addr_q, wr_addr_n;
    logic [DW-1:0] wrdata_q, wrdata_n;
    logic          ld_err_q, ld_err_n;
    logic          accept;
    logic [3:0]    cat;

    // Masks keep this valid down to DW=16, where the half-word fill is empty.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] data,
                                             input logic [1:0]    sz,
                                             input logic          sgn);
        logic [DW-1:0] res;
        res = data;
        if (LD_EXT != 0) begin
            if (sz == 2'b00) begin
                res = (data & ~BYTE_HI) | ((sgn && data[7]) ? BYTE_HI : '0);
            end else if (sz == 2'b01) begin
                res = (data & ~HALF_HI) | ((sgn && data[15]) ? HALF_HI : '0);
            end
        end
        return res;
    endfunction

    assign bus.ready   = (state == IDLE) && !rst;
    assign bus.busy    = (state == WAIT);
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wrdata  = wrdata_q;
    assign bus.ld_err  = ld_err_q;

    assign accept = bus.valid && bus.ready;
    assign cat    = bus.opcode[5:2];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rd_n      = rd_q;
        ldsz_n    = ldsz_q;
        ldsgn_n   = ldsgn_q;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wrdata_n  = wrdata_q;
        ld_err_n  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (cat)
                        `INSTR_OPCAT_ADDSUB, `INSTR_OPCAT_LOGIC, `INSTR_OPCAT_SHIFT: begin
                            wr_en_n   = (bus.rd != '0);
                            wr_addr_n = bus.rd;
                            wrdata_n  = bus.alu;
                        end
                        `INSTR_OPCAT_MOVE: begin
                            wr_en_n   = (bus.rd != '0);
                            wr_addr_n = bus.rd;
                            wrdata_n  = bus.opgen;
                        end
                        `INSTR_OPCAT_J: begin
                            wr_en_n   = (bus.rd != '0);
                            wr_addr_n = bus.rd;
                            wrdata_n  = bus.pc;
                        end
                        `INSTR_OPCAT_LD: begin
                            if (bus.mem_valid) begin
                                wr_en_n   = (bus.rd != '0);
                                wr_addr_n = bus.rd;
                                wrdata_n  = extend(bus.mem, bus.ldsz, bus.ldsgn);
                            end else begin
                                state_n = WAIT;
                                cnt_n   = '0;
                                rd_n    = bus.rd;
                                ldsz_n  = bus.ldsz;
                                ldsgn_n = bus.ldsgn;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                // Returning data takes priority over the timeout on the last cycle.
                if (bus.mem_valid) begin
                    wr_en_n   = (rd_q != '0);
                    wr_addr_n = rd_q;
                    wrdata_n  = extend(bus.mem, ldsz_q, ldsgn_q);
                    state_n   = IDLE;
                    cnt_n     = '0;
                end else if (cnt == TMO_LAST) begin
                    ld_err_n = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= '0;
            ldsz_q    <= '0;
            ldsgn_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wrdata_q  <= '0;
            ld_err_q  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_q      <= rd_n;
            ldsz_q    <= ldsz_n;
            ldsgn_q   <= ldsgn_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wrdata_q  <= wrdata_n;
            ld_err_q  <= ld_err_n;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// load-wait/timeout/reset sequences, and randomized traffic against a model.

module tb_wb_stage;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int TMO_TB = 4;

    localparam logic [3:0] CAT_ADDSUB = 4'd0;
    localparam logic [3:0] CAT_LOGIC  = 4'd1;
    localparam logic [3:0] CAT_SHIFT  = 4'd2;
    localparam logic [3:0] CAT_MOVE   = 4'd3;
    localparam logic [3:0] CAT_J      = 4'd4;
    localparam logic [3:0] CAT_LD     = 4'd5;
    localparam logic [3:0] CAT_ST     = 4'd6;

    typedef struct {
        logic [3:0]    cat;
        logic [AW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] opgen;
        logic [DW-1:0] pc;
        logic [DW-1:0] mem;
        logic          mem_valid;
        logic [1:0]    ldsz;
        logic          ldsgn;
        logic          exp_wr_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    // Model of the register-file port: last address/data written (held when idle).
    logic [AW-1:0] model_addr;
    logic [DW-1:0] model_data;

    vec_t vecs[12];

    wb_stage_if #(.DW(DW), .AW(AW)) bus ();

    wb_stage #(
        .DW(DW), .AW(AW), .TMO(TMO_TB), .LD_EXT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sub-word load result computed with plain integer arithmetic.
    function automatic logic [31:0] modelExtend(input logic [31:0] m, input logic [1:0] sz, input logic sgn);
        longint v;
        if (sz == 2'd0) begin
            v = longint'(m % 256);
            if (sgn && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = longint'(m % 65536);
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(m);
        end
        return 32'(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.valid     = 1'b1;
        bus.opcode    = {v.cat, 2'($urandom_range(0, 3))};
        bus.rd        = v.rd;
        bus.alu       = v.alu;
        bus.opgen     = v.opgen;
        bus.pc        = v.pc;
        bus.mem       = v.mem;
        bus.mem_valid = v.mem_valid;
        bus.ldsz      = v.ldsz;
        bus.ldsgn     = v.ldsgn;
    endtask

    // Compare the write port against the model; a write strobes unless rd is r0.
    task automatic checkWrite(input string tag, input logic expect_write);
        checkOutput({tag, ".wr_en"}, 32'(bus.wr_en), 32'(expect_write && (model_addr != '0)));
        checkOutput({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(model_addr));
        checkOutput({tag, ".wrdata"}, bus.wrdata, model_data);
        checkOutput({tag, ".ld_err"}, 32'(bus.ld_err), 32'd0);
    endtask

    // Issue a load whose data arrives on WAIT cycle 'delay' (0 = with the
    // accept, beyond TMO_TB = never), then check write or timeout and one idle cycle.
    task automatic doLoadWait(input logic [1:0] sz, input logic sgn, input int delay,
                              input logic [31:0] memv, input logic [AW-1:0] rdv, input string tag);
        bit done;
        bus.valid  = 1'b1;
        bus.opcode = {CAT_LD, 2'($urandom_range(0, 3))};
        bus.rd     = rdv;
        bus.ldsz   = sz;
        bus.ldsgn  = sgn;
        bus.alu    = 32'($urandom);
        if (delay == 0) begin
            bus.mem_valid = 1'b1;
            bus.mem       = memv;
            #1;
            checkOutput({tag, ".ready"}, 32'(bus.ready), 32'd1);
            tick();
            model_addr = rdv;
            model_data = modelExtend(memv, sz, sgn);
            checkWrite({tag, ".imm"}, 1'b1);
            checkOutput({tag, ".busy_imm"}, 32'(bus.busy), 32'd0);
        end else begin
            bus.mem_valid = 1'b0;
            bus.mem       = 32'($urandom);
            #1;
            checkOutput({tag, ".ready"}, 32'(bus.ready), 32'd1);
            tick();
            checkWrite({tag, ".accept"}, 1'b0);
            done = 1'b0;
            for (int k = 1; k <= TMO_TB && !done; k++) begin
                // Upstream noise while waiting must not be accepted or latched.
                bus.valid     = 1'($urandom_range(0, 1));
                bus.opcode    = 6'($urandom);
                bus.rd        = 5'($urandom);
                bus.ldsz      = 2'($urandom);
                bus.ldsgn     = 1'($urandom);
                bus.mem_valid = (k == delay);
                bus.mem       = (k == delay) ? memv : 32'($urandom);
                #1;
                checkOutput($sformatf("%s.busy_w%0d", tag, k), 32'(bus.busy), 32'd1);
                checkOutput($sformatf("%s.ready_w%0d", tag, k), 32'(bus.ready), 32'd0);
                tick();
                if (k == delay) begin
                    model_addr = rdv;
                    model_data = modelExtend(memv, sz, sgn);
                    checkWrite({tag, ".late"}, 1'b1);
                    done = 1'b1;
                end else if (k == TMO_TB) begin
                    checkOutput({tag, ".tmo_err"}, 32'(bus.ld_err), 32'd1);
                    checkOutput({tag, ".tmo_wr_en"}, 32'(bus.wr_en), 32'd0);
                    checkOutput({tag, ".tmo_addr"}, 32'(bus.wr_addr), 32'(model_addr));
                    checkOutput({tag, ".tmo_data"}, bus.wrdata, model_data);
                    done = 1'b1;
                end else begin
                    checkWrite($sformatf("%s.w%0d", tag, k), 1'b0);
                end
            end
        end
        bus.valid     = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        checkOutput({tag, ".ready_after"}, 32'(bus.ready), 32'd1);
        checkOutput({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
        tick();
        checkWrite({tag, ".after"}, 1'b0);
    endtask

    // Main sequence: reset, vector table, corner cases, then random traffic.
    initial begin
        rst           = 1'b1;
        bus.valid     = 1'b1;
        bus.opcode    = {CAT_ADDSUB, 2'b00};
        bus.rd        = 5'd1;
        bus.alu       = 32'h1111_1111;
        bus.opgen     = '0;
        bus.pc        = '0;
        bus.mem       = '0;
        bus.mem_valid = 1'b0;
        bus.ldsz      = 2'b00;
        bus.ldsgn     = 1'b0;
        model_addr    = '0;
        model_data    = '0;

        vecs[0]  = '{CAT_ADDSUB, 5'd3,  32'h0000_1234, 32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, 5'd3,  32'h0000_1234};
        vecs[1]  = '{CAT_MOVE,   5'd4,  32'($urandom), 32'hA5A5_A5A5, 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, 5'd4,  32'hA5A5_A5A5};
        vecs[2]  = '{CAT_J,      5'd31, 32'($urandom), 32'($urandom), 32'h0000_0100, 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, 5'd31, 32'h0000_0100};
        vecs[3]  = '{CAT_LOGIC,  5'd7,  32'hDEAD_BEEF, 32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, 5'd7,  32'hDEAD_BEEF};
        vecs[4]  = '{CAT_SHIFT,  5'd8,  32'h8000_0000, 32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1, 5'd8,  32'h8000_0000};
        vecs[5]  = '{CAT_LD,     5'd9,  32'($urandom), 32'($urandom), 32'($urandom), 32'h1234_8001, 1'b1, 2'b01, 1'b0, 1'b1, 5'd9,  32'h0000_8001};
        vecs[6]  = '{CAT_LD,     5'd10, 32'($urandom), 32'($urandom), 32'($urandom), 32'h1234_8001, 1'b1, 2'b01, 1'b1, 1'b1, 5'd10, 32'hFFFF_8001};
        vecs[7]  = '{CAT_LD,     5'd11, 32'($urandom), 32'($urandom), 32'($urandom), 32'hFFFF_FF7F, 1'b1, 2'b00, 1'b1, 1'b1, 5'd11, 32'h0000_007F};
        vecs[8]  = '{CAT_LD,     5'd12, 32'($urandom), 32'($urandom), 32'($urandom), 32'h8765_4321, 1'b1, 2'b10, 1'b1, 1'b1, 5'd12, 32'h8765_4321};
        vecs[9]  = '{CAT_ADDSUB, 5'd0,  32'h0000_0055, 32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b0, 5'd0,  32'h0000_0055};
        vecs[10] = '{CAT_ST,     5'd5,  32'h0000_0099, 32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b0, 5'd0,  32'h0000_0055};
        vecs[11] = '{CAT_LD,     5'd13, 32'($urandom), 32'($urandom), 32'($urandom), 32'hABCD_EFF0, 1'b1, 2'b11, 1'b1, 1'b1, 5'd13, 32'hABCD_EFF0};

        // Reset state, with a valid instruction presented that must be ignored.
        tick();
        tick();
        checkOutput("rst.ready", 32'(bus.ready), 32'd0);
        checkOutput("rst.wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("rst.wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("rst.wrdata", bus.wrdata, 32'd0);
        checkOutput("rst.ld_err", 32'(bus.ld_err), 32'd0);
        checkOutput("rst.busy", 32'(bus.busy), 32'd0);
        bus.valid = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("rst_release.ready", 32'(bus.ready), 32'd1);

        // Back-to-back single-cycle vectors; ready must stay high throughout.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d.ready", i), 32'(bus.ready), 32'd1);
            tick();
            checkOutput($sformatf("vec%0d.wr_en", i), 32'(bus.wr_en), 32'(vecs[i].exp_wr_en));
            checkOutput($sformatf("vec%0d.wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d.wrdata", i), bus.wrdata, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d.ld_err", i), 32'(bus.ld_err), 32'd0);
        end
        model_addr = 5'd13;
        model_data = 32'hABCD_EFF0;

        // Pulse ends when nothing new is accepted; stray mem_valid in IDLE ignored.
        bus.valid     = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem       = 32'h5555_5555;
        tick();
        checkWrite("pulse_end", 1'b0);
        bus.mem_valid = 1'b0;

        // Late byte loads, signed and unsigned, data on the third WAIT cycle.
        doLoadWait(2'b00, 1'b1, 3, 32'h0000_0080, 5'd14, "ld_byte_s");
        doLoadWait(2'b00, 1'b0, 3, 32'h0000_0080, 5'd15, "ld_byte_u");
        // Half load completing on accept never enters WAIT.
        doLoadWait(2'b01, 1'b0, 0, 32'h1234_8001, 5'd16, "ld_half_imm");
        // Timeout, and data arriving on the final wait cycle instead.
        doLoadWait(2'b10, 1'b0, 99, 32'hCAFE_F00D, 5'd17, "ld_tmo");
        doLoadWait(2'b10, 1'b0, TMO_TB, 32'hCAFE_F00D, 5'd18, "ld_last");

        // Reset during WAIT aborts the load silently.
        bus.valid     = 1'b1;
        bus.opcode    = {CAT_LD, 2'b00};
        bus.rd        = 5'd6;
        bus.ldsz      = 2'b10;
        bus.mem_valid = 1'b0;
        tick();
        bus.valid = 1'b0;
        #1;
        checkOutput("rstwait.busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstwait.ready_in_rst", 32'(bus.ready), 32'd0);
        tick();
        rst        = 1'b0;
        model_addr = '0;
        model_data = '0;
        checkWrite("rstwait.cleared", 1'b0);
        checkOutput("rstwait.busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < TMO_TB + 2; k++) begin
            bus.mem_valid = (k == 1);
            bus.mem       = 32'h7777_7777;
            tick();
            checkWrite($sformatf("rstwait.idle%0d", k), 1'b0);
        end
        bus.mem_valid = 1'b0;
        bus.valid     = 1'b1;
        bus.opcode    = {CAT_ADDSUB, 2'b10};
        bus.rd        = 5'd3;
        bus.alu       = 32'h0000_0077;
        tick();
        bus.valid  = 1'b0;
        model_addr = 5'd3;
        model_data = 32'h0000_0077;
        checkWrite("rstwait.recover", 1'b1);

        // Randomized traffic checked against the transaction-level model.
        for (int n = 0; n < 300; n++) begin
            int            sel;
            logic [3:0]    cat;
            logic [AW-1:0] rdv;
            logic [DW-1:0] av, ov, pv;
            sel = $urandom_range(0, 9);
            rdv = 5'($urandom);
            if (sel == 0) begin
                bus.valid     = 1'b0;
                bus.mem_valid = 1'($urandom);
                bus.mem       = 32'($urandom);
                tick();
                checkWrite("rnd.bubble", 1'b0);
            end else if (sel <= 3) begin
                doLoadWait(2'($urandom), 1'($urandom), $urandom_range(0, 6), 32'($urandom), rdv, "rnd.ld");
            end else begin
                cat = 4'($urandom_range(0, 8));
                if (cat == CAT_LD) cat = CAT_ST;
                av = 32'($urandom);
                ov = 32'($urandom);
                pv = 32'($urandom);
                bus.valid     = 1'b1;
                bus.opcode    = {cat, 2'($urandom)};
                bus.rd        = rdv;
                bus.alu       = av;
                bus.opgen     = ov;
                bus.pc        = pv;
                bus.mem       = 32'($urandom);
                bus.mem_valid = 1'($urandom);
                bus.ldsz      = 2'($urandom);
                bus.ldsgn     = 1'($urandom);
                tick();
                bus.valid = 1'b0;
                if (cat == CAT_ADDSUB || cat == CAT_LOGIC || cat == CAT_SHIFT) begin
                    model_addr = rdv;
                    model_data = av;
                    checkWrite("rnd.alu", 1'b1);
                end else if (cat == CAT_MOVE) begin
                    model_addr = rdv;
                    model_data = ov;
                    checkWrite("rnd.move", 1'b1);
                end else if (cat == CAT_J) begin
                    model_addr = rdv;
                    model_data = pv;
                    checkWrite("rnd.jump", 1'b1);
                end else begin
                    checkWrite("rnd.other", 1'b0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Registered, parametrised write-back stage, successor to the combinational write-back mux.
- Accepts one retiring instruction per cycle through a valid/ready handshake.
- Selects the result source by opcode category and applies sub-word load extension.
- Stalls on outstanding loads and times out if the load never returns.
- Issues a registered, single-cycle register-file write strobe. Sits between execute/memory access and the register file.

Parameters:
DW, 32, data/result width (>=16)
AW, 5, register address width
TMO, 15, max cycles waited for mem_valid_i before load abort (1..255)
LD_EXT, 1, 1 = honour ldsz_i/ldsgn_i; 0 = loads always full-word

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  upstream instruction valid
ready_o  out  1  stage can accept (combinational: state==IDLE && !rst)
opcode_i  in  6  opcode; category = opcode_i[5:2] per `INSTR_OPCAT_* macros
rd_i  in  AW  destination register
pc_i  in  DW  link value for jump-and-link
opgen_i  in  DW  operand_b from op_gen (move result)
alu_i  in  DW  ALU result
mem_i  in  DW  load data
mem_valid_i  in  1  load data valid
ldsz_i  in  2  00 byte, 01 half, 10/11 word
ldsgn_i  in  1  1 = sign-extend sub-word load
wr_en_o  out  1  register-file write strobe (one-cycle pulse)
wr_addr_o  out  AW  write address
wrdata_o  out  DW  write data
busy_o  out  1  high in WAIT
ld_err_o  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset, synchronous to clk: state=IDLE, cnt=0, wr_en_o=0, wr_addr_o=0, wrdata_o=0, ld_err_o=0, busy_o=0. ready_o=0 while rst is high.
- Accept = valid_i && ready_o. Inputs are sampled only on accept, except mem_i/mem_valid_i, which are also sampled in WAIT.
- IDLE, accepted category ADDSUB/LOGIC/SHIFT: next cycle wr_en_o=1, wrdata_o=alu_i.
- IDLE, accepted MOVE: next cycle wr_en_o=1, wrdata_o=opgen_i.
- IDLE, accepted J: next cycle wr_en_o=1, wrdata_o=pc_i.
- IDLE, accepted other non-LD category: consumed; wr_en_o=0 next cycle.
- IDLE, accepted LD with mem_valid_i=1 in the same cycle: write next cycle with extended mem_i. Stay IDLE.
- IDLE, accepted LD with mem_valid_i=0: latch rd_i/ldsz_i/ldsgn_i, cnt=0, go WAIT.
- Latency: 1 cycle from accept (or from mem_valid_i) to wr_en_o. Back-to-back non-load instructions give one write per cycle.
- wr_en_o is a pulse: it deasserts the following cycle unless a new write is produced.
- wr_addr_o = latched rd. wr_addr_o/wrdata_o hold their last value when wr_en_o=0.
- rd==0: wr_en_o forced 0 (r0 hardwired). Data/address still update.
- WAIT: ready_o=0, busy_o=1, cnt increments each cycle.
  - mem_valid_i=1: write next cycle with extended mem_i, go IDLE, cnt=0.
  - mem_valid_i=0 and cnt==TMO-1: no write, ld_err_o=1 next cycle for one cycle, go IDLE.
  - mem_valid_i=1 on the timeout cycle: the data wins; no error.
- Extension (LD_EXT=1):
  - byte: mem_i[7:0] extended to DW.
  - half: mem_i[15:0] extended to DW.
  - word: mem_i unchanged.
  - Sign extension when ldsgn_i=1, otherwise zero extension.
  - LD_EXT=0: word always.
- mem_valid_i in IDLE without an accepted LD is ignored.
- rst asserted during WAIT aborts the load: no write and no ld_err_o.
- Widths: all data paths are DW bits, with no truncation except sub-word selection.

Test Plan:
1. ADDSUB accepted with alu_i=0x0000_1234, rd_i=3 -> next cycle wr_en_o=1, wr_addr_o=3, wrdata_o=0x0000_1234; the cycle after, wr_en_o=0.
2. Back-to-back MOVE (opgen_i=0xA5A5_A5A5, rd=4) then J (pc_i=0x0000_0100, rd=31) -> two consecutive write pulses with those values; ready_o stays 1.
3. LD byte, ldsgn_i=1, mem_valid_i=0, then mem_i=0x0000_0080 with valid 3 cycles later -> ready_o=0 and busy_o=1 for 3 cycles; write of 0xFFFF_FF80; ldsgn_i=0 gives 0x0000_0080.
4. LD half with mem_valid_i=1 on accept, mem_i=0x1234_8001, ldsgn_i=0 -> write 0x0000_8001 next cycle; no WAIT entered.
5. LD with TMO=4 and mem_valid_i never asserted -> ld_err_o pulses 4 cycles after accept, no write, ready_o=1 again the next cycle; mem_valid_i on the final wait cycle instead gives a write and no error.
6. ADDSUB with rd=0 gives wr_en_o=0. rst pulsed during WAIT -> all outputs 0, IDLE, no ld_err_o; a later ADDSUB writes normally.
